// File: rtl/pheap_pkg.sv
// pheap_pkg: shared defaults and timestamp helper for the heap scheduler front end
package pheap_pkg;
    localparam int WIDTH_DEF   = 32;
    localparam int CMP_WID_DEF = 32;
    localparam int DEPTH_DEF   = 6;
    localparam int MAX_SIZE    = 2**DEPTH_DEF - 1;

    function automatic logic [CMP_WID_DEF-1:0] ts_of(input logic [WIDTH_DEF-1:0] ev);
        return ev[CMP_WID_DEF-1:0];
    endfunction
endpackage

// File: rtl/pheap_sched_front_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int PW = $clog2(N);

    always_comb begin
        gnt_idx = ptr;
        gnt     = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) gnt_idx = PW'((int'(ptr) + k) % N);
        if (|req) gnt[gnt_idx] = 1'b1;
    end
endmodule

// File: rtl/pheap_sched_front.sv
// pheap_sched_front: round-robin issue front end for the pipelined heap; PHEAP_SCHED_STATS_EN adds counters
module pheap_sched_front
    import pheap_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int CMP_WID    = CMP_WID_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int NUM_SRC    = 4,
    parameter int OP_GAP     = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]       src_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [CMP_WID-1:0]       min_ts,
    output logic                     heap_enq,
    output logic                     heap_deq,
    output logic [WIDTH-1:0]         heap_inp_data,
    input  logic [WIDTH-1:0]         heap_out_data,
    input  logic [DEPTH-1:0]         heap_elem_cnt,
    input  logic                     heap_full,
    input  logic                     heap_empty
`ifdef PHEAP_SCHED_STATS_EN
    ,
    output logic [31:0]              stat_enq,
    output logic [31:0]              stat_deq,
    output logic [31:0]              stat_full_stall,
    output logic [DEPTH-1:0]         stat_max_occ
`endif
);
    localparam int PW = $clog2(NUM_SRC);

    logic [3:0]         gap_q, gap_d, starve_q, starve_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [NUM_SRC-1:0] gnt;
    logic               slot, pend, force_enq, pop, enq;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req    (src_valid),
        .ptr    (rr_ptr_q),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    always_comb begin
        slot          = rst_n && gap_q == 4'd0;
        pend          = |src_valid && !heap_full;
        force_enq     = pend && starve_q >= 4'(STARVE_LIM);
        out_valid     = slot && !heap_empty && !force_enq;
        pop           = out_valid && out_ready;
        enq           = slot && !pop && pend;
        heap_deq      = pop;
        heap_enq      = enq;
        src_ready     = enq ? gnt : '0;
        out_data      = heap_out_data;
        heap_inp_data = src_data[gnt_idx*WIDTH +: WIDTH];
        min_ts        = heap_empty ? '1 : CMP_WID'(ts_of(WIDTH_DEF'(heap_out_data)));
        gap_d         = (pop || enq) ? 4'(OP_GAP) : (gap_q != 4'd0 ? gap_q - 4'd1 : 4'd0);
        rr_ptr_d      = !enq ? rr_ptr_q : (gnt_idx == PW'(NUM_SRC - 1) ? '0 : gnt_idx + PW'(1));
        starve_d      = (pop && pend) ? (starve_q == 4'hf ? starve_q : starve_q + 4'd1)
                      : ((enq || !pend) ? 4'd0 : starve_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_q    <= '0;
            rr_ptr_q <= '0;
            starve_q <= '0;
        end else begin
            gap_q    <= gap_d;
            rr_ptr_q <= rr_ptr_d;
            starve_q <= starve_d;
        end
    end

`ifdef PHEAP_SCHED_STATS_EN
    logic [31:0]      stat_enq_q, stat_enq_d, stat_deq_q, stat_deq_d, stat_full_stall_q, stat_full_stall_d;
    logic [DEPTH-1:0] stat_max_occ_q, stat_max_occ_d;

    always_comb begin
        stat_enq_d        = stat_enq_q + 32'(enq);
        stat_deq_d        = stat_deq_q + 32'(pop);
        stat_full_stall_d = stat_full_stall_q + 32'(|src_valid && heap_full);
        stat_max_occ_d    = heap_elem_cnt > stat_max_occ_q ? heap_elem_cnt : stat_max_occ_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_enq_q        <= '0;
            stat_deq_q        <= '0;
            stat_full_stall_q <= '0;
            stat_max_occ_q    <= '0;
        end else begin
            stat_enq_q        <= stat_enq_d;
            stat_deq_q        <= stat_deq_d;
            stat_full_stall_q <= stat_full_stall_d;
            stat_max_occ_q    <= stat_max_occ_d;
        end
    end

    assign stat_enq        = stat_enq_q;
    assign stat_deq        = stat_deq_q;
    assign stat_full_stall = stat_full_stall_q;
    assign stat_max_occ    = stat_max_occ_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^heap_elem_cnt;
`endif
endmodule

// File: tb/tb_pheap_sched_front.sv
// tb_pheap_sched_front: directed checks against a sorted-queue heap model
module tb_pheap_sched_front;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   src_valid;
    logic [127:0] src_data;
    logic [3:0]   src_ready;
    logic         out_valid, out_ready, heap_enq, heap_deq, heap_full, heap_empty;
    logic [31:0]  out_data, min_ts, heap_inp_data, heap_out_data;
    logic [5:0]   heap_elem_cnt;
    logic         m_full;
    logic [31:0]  mq[$];

    logic [3:0]   src_ready3;
    logic         out_valid3, out_ready3, heap_enq3, heap_deq3;
    logic [31:0]  out_data3, min_ts3, heap_inp_data3;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PHEAP_SCHED_STATS_EN
    logic [31:0] s_enq, s_deq, s_fs, s_enq3, s_deq3, s_fs3;
    logic [5:0]  s_occ, s_occ3;
`endif

    always #5 clk = ~clk;

    pheap_sched_front dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .min_ts(min_ts), .heap_enq(heap_enq), .heap_deq(heap_deq),
        .heap_inp_data(heap_inp_data), .heap_out_data(heap_out_data),
        .heap_elem_cnt(heap_elem_cnt), .heap_full(heap_full), .heap_empty(heap_empty)
`ifdef PHEAP_SCHED_STATS_EN
        , .stat_enq(s_enq), .stat_deq(s_deq), .stat_full_stall(s_fs), .stat_max_occ(s_occ)
`endif
    );

    pheap_sched_front #(.OP_GAP(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .src_valid(4'b0), .src_data(128'b0),
        .src_ready(src_ready3), .out_valid(out_valid3), .out_data(out_data3),
        .out_ready(out_ready3), .min_ts(min_ts3), .heap_enq(heap_enq3), .heap_deq(heap_deq3),
        .heap_inp_data(heap_inp_data3), .heap_out_data(32'h1234),
        .heap_elem_cnt(6'd10), .heap_full(1'b0), .heap_empty(1'b0)
`ifdef PHEAP_SCHED_STATS_EN
        , .stat_enq(s_enq3), .stat_deq(s_deq3), .stat_full_stall(s_fs3), .stat_max_occ(s_occ3)
`endif
    );

    // Heap model: root and count are registered, like the real pipelined heap
    always @(posedge clk) begin
        int p;
        if (!rst_n) mq.delete();
        else if (heap_enq) begin
            p = 0;
            while (p < mq.size() && mq[p] <= heap_inp_data) p++;
            mq.insert(p, heap_inp_data);
        end else if (heap_deq && mq.size() > 0) void'(mq.pop_front());
        heap_out_data <= mq.size() > 0 ? mq[0] : 32'h0;
        heap_elem_cnt <= 6'(mq.size());
    end

    assign heap_empty = heap_elem_cnt == 6'd0;
    assign heap_full  = m_full || heap_elem_cnt == 6'd63;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_src(input int i, input logic [31:0] d);
        src_data[i*32 +: 32] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; src_valid = 4'b0001; src_data = '0; out_ready = 1'b0;
        out_ready3 = 1'b0; m_full = 1'b0;
        set_src(0, 32'h30);
        repeat (3) cyc();
        #1;
        chk("rst_src_ready", 32'(src_ready), 32'h0);
        chk("rst_enq", 32'(heap_enq), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_gap", 32'(dut.gap_q), 32'h0);
        // single event round trip
        cyc(); rst_n = 1'b1; #1;
        chk("t1_enq", 32'(heap_enq), 32'h1);
        chk("t1_ready", 32'(src_ready), 32'h1);
        chk("t1_inp", heap_inp_data, 32'h30);
        cyc(); src_valid = 4'b0; #1;
        chk("t1_gap_enq", 32'(heap_enq), 32'h0);
        chk("t1_gap_valid", 32'(out_valid), 32'h0);
        cyc(); out_ready = 1'b1; #1;
        chk("t1_out_valid", 32'(out_valid), 32'h1);
        chk("t1_out_data", out_data, 32'h30);
        chk("t1_min_ts", min_ts, 32'h30);
        chk("t1_deq", 32'(heap_deq), 32'h1);
        cyc(); out_ready = 1'b0; #1;
        chk("t1_deq_once", 32'(heap_deq), 32'h0);
        chk("t1_min_ts_empty", min_ts, 32'hffffffff);
        // three simultaneous producers
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1; src_valid = 4'b0111;
        set_src(0, 32'h50); set_src(1, 32'h10); set_src(2, 32'h30); #1;
        chk("t2_g0", 32'(src_ready), 32'h1);
        chk("t2_g0_data", heap_inp_data, 32'h50);
        cyc(); src_valid = 4'b0110; #1;
        chk("t2_gap", 32'(heap_enq), 32'h0);
        cyc(); #1;
        chk("t2_g1", 32'(src_ready), 32'h2);
        chk("t2_g1_data", heap_inp_data, 32'h10);
        cyc(); src_valid = 4'b0100; #1;
        chk("t2_gap2", 32'(src_ready), 32'h0);
        cyc(); #1;
        chk("t2_g2", 32'(src_ready), 32'h4);
        chk("t2_g2_data", heap_inp_data, 32'h30);
        cyc(); src_valid = 4'b0;
        cyc(); out_ready = 1'b1; #1;
        chk("t2_pop0", out_data, 32'h10);
        chk("t2_pop0_deq", 32'(heap_deq), 32'h1);
        cyc(); #1;
        chk("t2_pop_gap", 32'(heap_deq), 32'h0);
        cyc(); #1;
        chk("t2_pop1", out_data, 32'h30);
        cyc(); cyc(); #1;
        chk("t2_pop2", out_data, 32'h50);
        chk("t2_pop2_deq", 32'(heap_deq), 32'h1);
        // full heap blocks grants
        cyc(); out_ready = 1'b0; m_full = 1'b1; src_valid = 4'b0010; set_src(1, 32'h77);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_full_ready", 32'(src_ready), 32'h0);
            chk("t3_full_enq", 32'(heap_enq), 32'h0);
            cyc();
        end
        m_full = 1'b0; #1;
        chk("t3_release_ready", 32'(src_ready), 32'h2);
        chk("t3_release_data", heap_inp_data, 32'h77);
        cyc(); src_valid = 4'b0;
        for (int v = 'h21; v <= 'h24; v++) begin
            cyc(); src_valid = 4'b0001; set_src(0, 32'(v)); #1;
            chk("t5_fill", 32'(heap_enq), 32'h1);
            cyc(); src_valid = 4'b0;
        end
        // enqueue anti-starvation
        cyc(); out_ready = 1'b1; src_valid = 4'b1000; set_src(3, 32'h05); #1;
        chk("t5_pop0", out_data, 32'h21);
        chk("t5_pop0_deq", 32'(heap_deq), 32'h1);
        for (int i = 1; i < 4; i++) begin
            cyc(); #1;
            chk("t5_gap_deq", 32'(heap_deq), 32'h0);
            cyc(); #1;
            chk("t5_pop", out_data, 32'h21 + 32'(i));
            chk("t5_pop_deq", 32'(heap_deq), 32'h1);
        end
        cyc(); cyc(); #1;
        chk("t5_force_valid", 32'(out_valid), 32'h0);
        chk("t5_force_deq", 32'(heap_deq), 32'h0);
        chk("t5_force_enq", 32'(heap_enq), 32'h1);
        chk("t5_force_ready", 32'(src_ready), 32'h8);
        chk("t5_force_data", heap_inp_data, 32'h05);
        cyc(); src_valid = 4'b0; #1;
        chk("t5_starve_clr", 32'(dut.starve_q), 32'h0);
        cyc(); #1;
        chk("t5_after_pop", out_data, 32'h05);
        chk("t5_after_deq", 32'(heap_deq), 32'h1);
        cyc(); out_ready = 1'b0;
        // reset in the middle of a gap
        cyc(); src_valid = 4'b0001; set_src(0, 32'h99); #1;
        chk("t6_enq", 32'(heap_enq), 32'h1);
        cyc(); rst_n = 1'b0; set_src(0, 32'hAA); #1;
        chk("t6_gap_one", 32'(dut.gap_q), 32'h1);
        chk("t6_rst_ready", 32'(src_ready), 32'h0);
        chk("t6_rst_enq", 32'(heap_enq), 32'h0);
        chk("t6_rst_valid", 32'(out_valid), 32'h0);
        cyc(); rst_n = 1'b1; #1;
        chk("t6_gap_zero", 32'(dut.gap_q), 32'h0);
        chk("t6_first_enq", 32'(heap_enq), 32'h1);
        chk("t6_first_data", heap_inp_data, 32'hAA);
        cyc(); src_valid = 4'b0;
        // OP_GAP=3 pop cadence
        cyc(); out_ready3 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("t4_deq_cadence", 32'(heap_deq3), (k % 4 == 0) ? 32'h1 : 32'h0);
            cyc();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
